// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame
// geometry used by the transmitter, receiver and baud tick generator.
package uart_pkg;

    localparam int OVERSAMPLING_DEF = 8;
    localparam int DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Byte hand-off from the UART receiver to its consumer (valid/ready).
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) ();

    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs that idle high (RXD, CTS).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: both flops reset to 1 so an idle-high line never looks like a start edge out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: samples rxd on baud ticks, delivers bytes on a
// valid/ready port and pulses framing_err / overrun for the status register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING = OVERSAMPLING_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rxd,
    uart_rx_if.master  bus,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    localparam int OS_W = $clog2(OVERSAMPLING);
    localparam int BC_W = $clog2(DATA_BITS + 1);

    localparam logic [2:0] IDLE  = RX_IDLE;
    localparam logic [2:0] START = RX_START;
    localparam logic [2:0] DATA  = RX_DATA;
    localparam logic [2:0] STOP  = RX_STOP;
    localparam logic [2:0] BREAK = RX_BREAK;

    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLING / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLING - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic [2:0]           state;
    logic [OS_W-1:0]      os_cnt;
    logic [BC_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 stop_tick;
    logic                 deliver;
    logic                 frame_bad;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rx_s)
    );

    // The stop-bit centre sample decides between delivery and a framing error.
    assign stop_tick = tick && (state == STOP) && (os_cnt == OS_LAST);
    assign deliver   = stop_tick && rx_s;
    assign frame_bad = stop_tick && !rx_s;
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        os_cnt <= '0;
                    end
                end
                START: begin
                    if (os_cnt == OS_HALF) begin
                        os_cnt  <= '0;
                        bit_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        os_cnt <= os_cnt + OS_W'(1);
                    end
                end
                DATA: begin
                    if (os_cnt == OS_LAST) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        os_cnt  <= '0;
                        bit_cnt <= bit_cnt + BC_W'(1);
                        if (bit_cnt == BC_LAST) state <= STOP;
                    end else begin
                        os_cnt <= os_cnt + OS_W'(1);
                    end
                end
                STOP: begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt <= '0;
                        state  <= rx_s ? IDLE : BREAK;
                    end else begin
                        os_cnt <= os_cnt + OS_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A full holding register that is not being drained drops the new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            overrun     <= deliver && valid_q && !bus.out_ready;
            if (deliver && (!valid_q || bus.out_ready)) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver, 8N1 by default.
- Sits directly downstream of the baud tick generator: consumes its `tick` (Baud × OVERSAMPLING rate) as a sample strobe, deserialises `rxd` and presents bytes on a valid/ready interface.
- Flags framing errors and overruns for the SoC UART status register.

Parameters:
- OVERSAMPLING, 8, ticks per bit period; must be even and ≥4.
- DATA_BITS, 8, data bits per frame; range 5..8; LSB first.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-clk-wide oversample strobe from the baud tick generator
- rxd  in  1  asynchronous serial input; idle high
- out_data  out  DATA_BITS  received byte; stable while out_valid=1
- out_valid  out  1  byte available
- out_ready  in  1  consumer accepts; transfer happens when out_valid && out_ready at posedge clk
- framing_err  out  1  one-clk pulse: stop bit sampled low
- overrun  out  1  one-clk pulse: new byte dropped because the holding register was still full
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async assert, clk-synchronous deassert handled upstream):
  - state=IDLE; sync FFs=1; counters=0; shift register=0.
  - out_data=0; out_valid=0; framing_err=0; overrun=0; busy=0.
- Input sync: `rxd` passes through 2 FFs reset to 1. All decisions use the 2nd FF (rx_s).
- Sampling: every counter update and sample happens only on clk edges with tick=1. Cycles with tick=0 hold all state. There is no dependence on tick spacing.
- State machine (os_cnt width clog2(OVERSAMPLING); bit_cnt width clog2(DATA_BITS+1)):
  - IDLE: on tick with rx_s=0 → START, os_cnt=0.
  - START: on tick, os_cnt++.
    - At os_cnt == OVERSAMPLING/2-1, check rx_s.
    - rx_s=0 → DATA, os_cnt=0, bit_cnt=0.
    - rx_s=1 → IDLE (glitch rejected; no flag).
  - DATA: on tick, os_cnt++.
    - At os_cnt == OVERSAMPLING-1 (bit centre): shift rx_s into MSB of shreg (right shift, so LSB-first arrival), os_cnt=0, bit_cnt++.
    - When bit_cnt reaches DATA_BITS → STOP.
  - STOP: at os_cnt == OVERSAMPLING-1 tick, sample rx_s.
    - 1 → deliver byte, → IDLE.
    - 0 → framing_err pulse, byte discarded, → BREAK.
  - BREAK: stay until tick with rx_s=1 → IDLE. A held-low line produces exactly one framing_err.
- Delivery (same clk as the stop sample):
  - out_valid=0, or out_valid=1 with out_ready=1 that cycle: load out_data, out_valid=1.
  - out_valid=1 and out_ready=0: keep old byte, pulse overrun.
- Consumption: out_valid && out_ready with no delivery that cycle → out_valid=0 next clk. out_data holds its last value.
- Latency: out_valid rises 1 clk after the tick that samples the stop-bit centre. Stop-bit centre ≈ (1.5 + DATA_BITS) bit periods after the falling edge, plus 2 clk sync delay.
- framing_err and overrun are registered, 1 clk wide, mutually exclusive.
- rst asserted mid-frame: immediate return to IDLE, partial byte lost, out_valid cleared.
- A new start edge arriving during STOP/BREAK is not detected until IDLE. After a good stop, the receiver can detect the next start edge on the following tick.

Decomposition:
- Shared package uart_pkg:
  - rx state enum {IDLE, START, DATA, STOP, BREAK}.
  - Default OVERSAMPLING/DATA_BITS constants, shared with the transmitter and the baud tick generator instance parameters.
- One sub-module: uart_rx_sync, the 2-FF synchroniser with reset value 1. It is reused by other async inputs (CTS).

Test Plan:
All cases use OVERSAMPLING=8, DATA_BITS=8, tick every 4 clk, bit period = 32 clk.
- Send 0xA5, out_ready=1 → one-clk out_valid with out_data=0xA5; framing_err=0; overrun=0; busy low afterwards.
- Low glitch on rxd lasting 8 clk (2 ticks) while idle → state returns to IDLE; no out_valid, no flags.
- Send 0x3C with stop bit forced 0, then rxd held low for 320 clk, then high → exactly one framing_err pulse; no out_valid; next frame 0x55 received correctly.
- out_ready=0; send 0x11 then 0x22 back-to-back → out_data=0x11 valid; overrun pulse at end of 2nd frame; out_data still 0x11. After out_ready=1, out_valid drops.
- out_valid=1 with 0x11 held; out_ready pulsed high exactly on the 2nd frame's delivery clk → no overrun; out_data=0x22; out_valid stays 1.
- Assert rst at bit 4 of a frame → all outputs 0 immediately. After release, frame 0xF0 received correctly.
